// File: rtl/multi_digit_display_scan_if.sv
// Bundle between the datapath and the seven-segment scan driver:
// digit data, load strobe and enables in, segment/anode drive out.
interface multi_digit_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits_in, load, digit_en, lz_blank,
    input  seg, an, frame_start
  );

  modport slave (
    input  digits_in, load, digit_en, lz_blank,
    output seg, an, frame_start
  );
endinterface

// File: rtl/multi_digit_display_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver with dwell/blank
// timing, double-buffered digit data, per-digit enables and leading-zero blanking.
module multi_digit_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 75000,
  parameter int BLANK_TICKS = 1200
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_digit_display_scan_if.slave     bus
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW        = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'h0:    seg_v = 7'h40;
      4'h1:    seg_v = 7'h79;
      4'h2:    seg_v = 7'h24;
      4'h3:    seg_v = 7'h30;
      4'h4:    seg_v = 7'h19;
      4'h5:    seg_v = 7'h12;
      4'h6:    seg_v = 7'h02;
      4'h7:    seg_v = 7'h78;
      4'h8:    seg_v = 7'h00;
      4'h9:    seg_v = 7'h10;
      4'hA:    seg_v = 7'h08;
      4'hB:    seg_v = 7'h03;
      4'hC:    seg_v = 7'h46;
      4'hD:    seg_v = 7'h21;
      4'hE:    seg_v = 7'h06;
      4'hF:    seg_v = 7'h0E;
      default: seg_v = 7'h7F;
    endcase
    return seg_v;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic              enter_show_s;
  logic              frame_edge_s;

  logic [DW-1:0]         pending_r, pending_nxt_s;
  logic [DW-1:0]         display_r, display_nxt_s;
  logic [NUM_DIGITS-1:0] nz_above_s;
  logic [NUM_DIGITS-1:0] lit_vec_s;
  logic                  nz_acc_s;
  logic                  lit_sel_s;
  logic [3:0]            sel_nib_s;
  logic                  show_nxt_s;

  logic [6:0]            seg_r, seg_nxt_s;
  logic [NUM_DIGITS-1:0] an_r, an_nxt_s;
  logic                  frame_start_r;

  // Scan sequencing: dwell/blank counting and digit index advance.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r + CNT_W'(1'b1);
    idx_nxt_s    = idx_r;
    enter_show_s = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s  = ST_SHOW;
          cnt_nxt_s    = '0;
          enter_show_s = 1'b1;
        end else begin
          state_nxt_s  = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_r == DIGIT_LAST) begin
          cnt_nxt_s = '0;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = '0;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1'b1);
          end
          // With no gap configured, the next digit starts straight away.
          if (BLANK_TICKS == 0) begin
            state_nxt_s  = ST_SHOW;
            enter_show_s = 1'b1;
          end else begin
            state_nxt_s  = ST_BLANK;
          end
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = '0;
        idx_nxt_s   = '0;
      end
    endcase
    frame_edge_s = enter_show_s && (idx_nxt_s == '0);
  end

  // Buffer updates, lit/blanking rule and next registered output values.
  always_comb begin
    if (bus.load) begin
      pending_nxt_s = bus.digits_in;
    end else begin
      pending_nxt_s = pending_r;
    end

    // Frame boundary swaps in the newest data; a coincident load bypasses pending.
    if (frame_edge_s) begin
      display_nxt_s = bus.load ? bus.digits_in : pending_r;
    end else begin
      display_nxt_s = display_r;
    end

    nz_acc_s = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz_acc_s      = nz_acc_s | (display_nxt_s[4*k +: 4] != 4'h0);
      nz_above_s[k] = nz_acc_s;
    end

    show_nxt_s = (state_nxt_s == ST_SHOW);
    lit_sel_s  = 1'b0;
    sel_nib_s  = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lit_vec_s[k] = bus.digit_en[k] & (~bus.lz_blank | (k == 0) | nz_above_s[k]);
      lit_sel_s    = lit_sel_s | ((idx_nxt_s == IDX_W'(k)) & lit_vec_s[k]);
      sel_nib_s    = sel_nib_s | ((idx_nxt_s == IDX_W'(k)) ? display_nxt_s[4*k +: 4] : 4'h0);
      an_nxt_s[k]  = ~(show_nxt_s & (idx_nxt_s == IDX_W'(k)) & lit_vec_s[k]);
    end

    if (show_nxt_s && lit_sel_s) begin
      seg_nxt_s = hex_to_seg(sel_nib_s);
    end else begin
      seg_nxt_s = 7'h7F;
    end
  end

  // State, buffers and display outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_BLANK;
      cnt_r         <= '0;
      idx_r         <= '0;
      pending_r     <= '0;
      display_r     <= '0;
      seg_r         <= 7'h7F;
      an_r          <= '1;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      idx_r         <= idx_nxt_s;
      pending_r     <= pending_nxt_s;
      display_r     <= display_nxt_s;
      seg_r         <= seg_nxt_s;
      an_r          <= an_nxt_s;
      frame_start_r <= frame_edge_s;
    end
  end

  assign bus.seg         = seg_r;
  assign bus.an          = an_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_multi_digit_display_scan.sv
// Bench for the scan driver: a 4-digit/4-tick/2-blank instance and a
// 2-digit/3-tick/no-gap instance, both compared against a slot-arithmetic model.
module tb_multi_digit_display_scan;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  multi_digit_display_scan_if #(.NUM_DIGITS(4)) bus_a ();
  multi_digit_display_scan_if #(.NUM_DIGITS(2)) bus_b ();

  multi_digit_display_scan #(.NUM_DIGITS(4), .DIGIT_TICKS(4), .BLANK_TICKS(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  multi_digit_display_scan #(.NUM_DIGITS(2), .DIGIT_TICKS(3), .BLANK_TICKS(0)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  int nd [2] = '{4, 2};
  int dt [2] = '{4, 3};
  int bt [2] = '{2, 0};

  int          t_m     [2];
  logic [31:0] pend_m  [2];
  logic [31:0] disp_m  [2];
  bit          valid_m [2] = '{1'b0, 1'b0};

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Position of cycle t (cycles since the reset edge) within the scan frame.
  function automatic void slot_of(input int u, input int t, output bit show,
                                  output int idx, output bit fs);
    int p;
    int slot_len;
    show = 1'b0;
    idx  = 0;
    fs   = 1'b0;
    if (bt[u] == 0 && t == 0) return;
    slot_len = dt[u] + bt[u];
    p    = ((bt[u] == 0) ? t - 1 : t) % (nd[u] * slot_len);
    idx  = p / slot_len;
    show = (p % slot_len) >= bt[u];
    fs   = show && (idx == 0) && ((p % slot_len) == bt[u]);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input bit rs, input bit ld, input logic [31:0] dg,
                            input logic [7:0] en, input bit lz, input logic [7:0] obs_an,
                            input logic [6:0] obs_seg, input logic obs_fs);
    bit         show;
    bit         fs;
    bit         lit;
    int         idx;
    logic [3:0] nib;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    if (rs) begin
      t_m[u]     = 0;
      pend_m[u]  = 32'h0;
      disp_m[u]  = 32'h0;
      valid_m[u] = 1'b1;
    end else if (valid_m[u]) begin
      t_m[u]++;
      if (ld) pend_m[u] = dg;
      slot_of(u, t_m[u], show, idx, fs);
      if (fs) disp_m[u] = pend_m[u];
    end
    if (valid_m[u]) begin
      slot_of(u, t_m[u], show, idx, fs);
      nib     = 4'((disp_m[u] >> (4 * idx)) & 32'hF);
      lit     = en[idx] && (!lz || idx == 0 || (disp_m[u] >> (4 * idx)) != 32'h0);
      exp_an  = 8'((1 << nd[u]) - 1);
      exp_seg = 7'h7F;
      if (show && lit) begin
        exp_an[idx] = 1'b0;
        exp_seg     = seg_tab[nib];
      end
      check((u == 0) ? "a_an" : "b_an", obs_an, exp_an);
      check((u == 0) ? "a_seg" : "b_seg", {1'b0, obs_seg}, {1'b0, exp_seg});
      check((u == 0) ? "a_frame_start" : "b_frame_start", {7'h00, obs_fs}, {7'h00, fs});
    end
  endtask

  // One clock: capture the applied inputs, let the edge pass, compare both units.
  task automatic step();
    bit          rs_a, ld_a, lz_a, rs_b, ld_b, lz_b;
    logic [31:0] dg_a, dg_b;
    logic [7:0]  en_a, en_b;
    rs_a = rst_a;  ld_a = bus_a.load;  lz_a = bus_a.lz_blank;
    dg_a = {16'h0000, bus_a.digits_in};  en_a = {4'h0, bus_a.digit_en};
    rs_b = rst_b;  ld_b = bus_b.load;  lz_b = bus_b.lz_blank;
    dg_b = {24'h000000, bus_b.digits_in};  en_b = {6'h00, bus_b.digit_en};
    @(posedge clk);
    #1;
    model_step(0, rs_a, ld_a, dg_a, en_a, lz_a, {4'h0, bus_a.an}, bus_a.seg, bus_a.frame_start);
    model_step(1, rs_b, ld_b, dg_b, en_b, lz_b, {6'h00, bus_b.an}, bus_b.seg, bus_b.frame_start);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance unit A until its current cycle sits at frame phase ph (0..23).
  task automatic run_until_a(input int ph);
    for (int i = 0; i < 100 && (t_m[0] % 24) != ph; i++) step();
    vectors++;
    assert ((t_m[0] % 24) == ph) else begin
      miscompares++;
      $error("FAIL a_phase_wait: observed %0d expected %0d", t_m[0] % 24, ph);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.digits_in = 16'h0000;  bus_a.load = 1'b0;  bus_a.digit_en = 4'hF;  bus_a.lz_blank = 1'b0;
    bus_b.digits_in = 8'h00;     bus_b.load = 1'b0;  bus_b.digit_en = 2'b11; bus_b.lz_blank = 1'b0;
    run(2);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Free scan with cleared buffers.
    run(48);

    // Mid-frame load waits for the next frame boundary.
    run_until_a(10);
    bus_a.digits_in = 16'h1A08;  bus_a.load = 1'b1;
    bus_b.digits_in = 8'h5C;     bus_b.load = 1'b1;
    run(48);

    // Load coincident with the frame boundary is taken by the same frame.
    run_until_a(1);
    bus_a.digits_in = 16'h00F3;  bus_a.load = 1'b1;
    run(30);

    // Leading-zero blanking.
    bus_a.lz_blank = 1'b1;
    bus_b.lz_blank = 1'b1;
    bus_a.digits_in = 16'h0005;  bus_a.load = 1'b1;
    bus_b.digits_in = 8'h07;     bus_b.load = 1'b1;
    run(48);
    bus_a.digits_in = 16'h0000;  bus_a.load = 1'b1;
    bus_b.digits_in = 8'h00;     bus_b.load = 1'b1;
    run(48);
    bus_a.lz_blank = 1'b0;
    bus_b.lz_blank = 1'b0;

    // Per-digit enable.
    bus_a.digit_en = 4'b1011;
    bus_a.digits_in = 16'h1234;  bus_a.load = 1'b1;
    bus_b.digit_en = 2'b01;
    run(30);
    bus_a.digit_en = 4'hF;
    bus_b.digit_en = 2'b11;

    // Reset pulse in the middle of digit 2's show interval.
    run_until_a(15);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    run(30);

    // Randomised traffic on both units.
    for (int i = 0; i < 700; i++) begin
      rst_a = ($urandom_range(249, 0) == 0);
      rst_b = ($urandom_range(249, 0) == 0);
      bus_a.load = ($urandom_range(5, 0) == 0);
      bus_b.load = ($urandom_range(5, 0) == 0);
      bus_a.digits_in = ($urandom_range(1, 0) == 0) ? 16'($urandom) : 16'($urandom_range(255, 0));
      bus_b.digits_in = ($urandom_range(1, 0) == 0) ? 8'($urandom) : 8'($urandom_range(15, 0));
      if ($urandom_range(19, 0) == 0) bus_a.digit_en = 4'($urandom);
      if ($urandom_range(19, 0) == 0) bus_b.digit_en = 2'($urandom);
      if ($urandom_range(29, 0) == 0) bus_a.lz_blank = ~bus_a.lz_blank;
      if ($urandom_range(29, 0) == 0) bus_b.lz_blank = ~bus_b.lz_blank;
      step();
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_digit_display_scan.md
Name: multi_digit_display_scan

Overview:
- Parametrised N-digit, time-multiplexed seven-segment display driver. Generalises the two-display multiplexer to NUM_DIGITS digits.
- Adds a programmable per-digit dwell time, an anti-ghosting blank gap between digits, and double-buffered digit loading.
- Adds per-digit enables and optional leading-zero blanking.
- Sits between the datapath (sum/counter logic) and the board's common-anode display pins. Replaces the separate clock-divider/mux/decoder trio.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- DIGIT_TICKS, 75000, clk cycles each digit is driven; must be >= 1.
- BLANK_TICKS, 1200, clk cycles of all-off gap before each digit; 0 skips the gap.

Ports:
- clk  in  1  system clock (HSOSC-derived).
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble k = digits_in[4k+3:4k]; digit 0 is least significant (rightmost).
- load  in  1  single-cycle strobe; captures digits_in into the pending buffer.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
- lz_blank  in  1  1 enables leading-zero blanking.
- seg  out  7  active-low segments, seg[0]=a .. seg[6]=g.
- an  out  NUM_DIGITS  active-low anode drive; an[k] low lights digit k.
- frame_start  out  1  one-cycle pulse when digit 0's SHOW interval begins.

Behaviour:
- Reset (clk edge with reset=1):
  - an = all 1s, seg = 7'h7F, frame_start = 0.
  - state = BLANK, idx = 0, tick counter = 0.
  - pending and display buffers cleared to 0.
  - load is ignored while reset=1.
  - Reset asserted mid-scan aborts immediately to this state on that edge.
- FSM states: BLANK and SHOW. One tick counter, width $clog2(max(DIGIT_TICKS, BLANK_TICKS)+1).
- BLANK:
  - Lasts BLANK_TICKS cycles. an = all 1s, seg = 7'h7F.
  - On the last cycle, go to SHOW with the counter cleared.
  - If BLANK_TICKS = 0, BLANK is never occupied; transitions go straight SHOW->SHOW.
- SHOW:
  - Lasts DIGIT_TICKS cycles.
  - an = ~(1 << idx) if digit idx is lit, else all 1s.
  - seg = decode(display[idx]) if lit, else 7'h7F.
  - On the last cycle, idx wraps idx+1 mod NUM_DIGITS and the FSM enters BLANK (or SHOW if BLANK_TICKS = 0).
- Outputs are registered and change on the same edge as the state/idx update. No combinational path from inputs to outputs.
- Scan timing: after reset deasserts, the first BLANK_TICKS cycles are dark, then digit 0 shows. Frame period = NUM_DIGITS*(DIGIT_TICKS+BLANK_TICKS) cycles.
- frame_start is high for exactly the first cycle of each SHOW with idx = 0.
- Double buffering:
  - load=1 writes pending <= digits_in.
  - display <= pending on the edge that enters SHOW for idx 0 (frame boundary), so a frame never tears.
  - If load coincides with the frame-boundary edge, display <= digits_in directly (bypass).
  - Multiple loads within one frame: last one wins.
- Lit rule: digit k is lit iff digit_en[k] = 1 AND it is not LZ-blanked. digit_en and lz_blank are sampled live each cycle, not buffered.
- LZ-blank: when lz_blank=1, digit k (k >= 1) is blanked iff display[j] = 0 for all j >= k. Digit 0 is never LZ-blanked.
- Decoder (hex, active-low, {g,f,e,d,c,b,a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- NUM_DIGITS = 1: idx is held at 0; the FSM still alternates BLANK/SHOW.

Test Plan (NUM_DIGITS=4, DIGIT_TICKS=4, BLANK_TICKS=2 unless noted):
- Reset then release with no load:
  - an sequence per cycle: 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4, repeat.
  - seg = 7'h40 during every SHOW.
  - frame_start pulses once every 24 cycles.
- load with digits_in = 16'h1A08 mid-frame:
  - No change until the next frame_start.
  - Then digit 0 seg = 7'h00 (8), digit 1 = 7'h40 (0), digit 2 = 7'h08 (A), digit 3 = 7'h79 (1).
- Coincident load and frame boundary with 16'h00F3 asserted on that edge:
  - Digit 0 of the same frame shows 7'h30 (3).
  - Digit 1 shows 7'h0E (F).
- lz_blank=1, display = 16'h0005:
  - an[3:1] stay high in every slot; digit 0 shows 7'h12 (5).
  - With display = 16'h0000, only digit 0 lights, showing 7'h40.
- digit_en = 4'b1011:
  - During idx=2's SHOW, an = 1111 and seg = 7'h7F.
  - Other digits scan normally.
- Assert reset for 1 cycle during digit 2 SHOW:
  - Next cycle an = 1111, seg = 7'h7F, buffers = 0.
  - Scan restarts with 2 dark cycles, then digit 0.
- BLANK_TICKS=0, NUM_DIGITS=2, DIGIT_TICKS=3:
  - an = 10 x3, 01 x3, repeating with no dark cycles.
